// File: rtl/wb_pkg.sv
// wb_pkg: shared widths, source ids and buffer entry type
// for the register-file write-back arbiter.
package wb_pkg;
  localparam int WB_DATA_W = 32;
  localparam int WB_ADDR_W = 5;

  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_MEM = 1'b1;

  typedef struct packed {
    logic                 vld;
    logic [WB_ADDR_W-1:0] addr;
    logic [WB_DATA_W-1:0] data;
    logic                 age;
  } wb_entry_t;

  function automatic logic addr_hit(
    input logic                 vld,
    input logic [WB_ADDR_W-1:0] a,
    input logic [WB_ADDR_W-1:0] q
  );
    return vld && (a == q);
  endfunction
endpackage

// File: rtl/wb_port_arbiter_if.sv
// wb_port_arbiter_if: producer requests, register-file write port
// and decode hazard queries.
interface wb_port_arbiter_if #(
  parameter int DATA_W = wb_pkg::WB_DATA_W,
  parameter int ADDR_W = wb_pkg::WB_ADDR_W
);
  logic              s0_valid;
  logic [ADDR_W-1:0] s0_addr;
  logic [DATA_W-1:0] s0_data;
  logic              s0_ready;
  logic              s1_valid;
  logic [ADDR_W-1:0] s1_addr;
  logic [DATA_W-1:0] s1_data;
  logic              s1_ready;
  logic              write;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic [ADDR_W-1:0] q_addr_1;
  logic [ADDR_W-1:0] q_addr_2;
  logic              q_busy_1;
  logic              q_busy_2;

  modport master (
    output s0_valid, s0_addr, s0_data,
    output s1_valid, s1_addr, s1_data,
    output q_addr_1, q_addr_2,
    input  s0_ready, s1_ready,
    input  write, wb_addr, wb_data,
    input  q_busy_1, q_busy_2
  );

  modport slave (
    input  s0_valid, s0_addr, s0_data,
    input  s1_valid, s1_addr, s1_data,
    input  q_addr_1, q_addr_2,
    output s0_ready, s1_ready,
    output write, wb_addr, wb_data,
    output q_busy_1, q_busy_2
  );
endinterface

// File: rtl/wb_hold_buf.sv
// wb_hold_buf: one-entry holding buffer for a write-back source;
// writes to $0 are accepted but never stored.
module wb_hold_buf
  import wb_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid,
  input  logic [WB_ADDR_W-1:0] addr,
  input  logic [WB_DATA_W-1:0] data,
  input  logic                 grant,
  input  logic                 age,
  output logic                 ready,
  output wb_entry_t            entry
);
  logic load;

  assign ready = !entry.vld || grant;
  assign load  = valid && ready && (addr != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      entry <= '0;
    end else if (load) begin
      entry.vld  <= 1'b1;
      entry.addr <= addr;
      entry.data <= data;
      entry.age  <= age;
    end else if (grant) begin
      entry.vld <= 1'b0;
    end
  end
endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: grants one buffered write-back per cycle onto
// the register file port and flags pending-write hazards.
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int DATA_W     = WB_DATA_W,
  parameter int ADDR_W     = WB_ADDR_W,
  parameter int STARVE_MAX = 4
) (
  input logic              clk,
  input logic              reset,
  wb_port_arbiter_if.slave bus
);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  wb_entry_t         b0;
  wb_entry_t         b1;
  logic [1:0]        grant;
  logic              age0;
  logic              age1;
  logic              ld1;
  logic [3:0]        starve;
  logic              write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              both;
  logic              by_age;
  logic              forced;

  assign both   = b0.vld && b1.vld;
  assign by_age = both && (b0.addr == b1.addr)
                && (b0.age != b1.age);
  assign forced = both && !by_age
                && (starve == STARVE_LIM);

  always_comb begin
    grant = '0;
    unique case (1'b1)
      !both: begin
        grant[SRC_ALU] = b0.vld;
        grant[SRC_MEM] = b1.vld;
      end
      by_age: begin
        grant[SRC_MEM] = !b1.age;
        grant[SRC_ALU] = b1.age;
      end
      forced:  grant[SRC_MEM] = 1'b1;
      default: grant[SRC_ALU] = 1'b1;
    endcase
  end

  // same-edge same-address loads: source 1 is treated as older
  assign ld1  = bus.s1_valid && bus.s1_ready
              && (bus.s1_addr != '0);
  assign age0 = (b1.vld && !grant[SRC_MEM])
              || (ld1 && (bus.s1_addr == bus.s0_addr));
  assign age1 = b0.vld && !grant[SRC_ALU];

  wb_hold_buf u_buf0 (
    .clk   (clk),
    .reset (reset),
    .valid (bus.s0_valid),
    .addr  (bus.s0_addr),
    .data  (bus.s0_data),
    .grant (grant[SRC_ALU]),
    .age   (age0),
    .ready (bus.s0_ready),
    .entry (b0)
  );

  wb_hold_buf u_buf1 (
    .clk   (clk),
    .reset (reset),
    .valid (bus.s1_valid),
    .addr  (bus.s1_addr),
    .data  (bus.s1_data),
    .grant (grant[SRC_MEM]),
    .age   (age1),
    .ready (bus.s1_ready),
    .entry (b1)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve  <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      if (!b1.vld || grant[SRC_MEM]) begin
        starve <= '0;
      end else if (starve != STARVE_LIM) begin
        starve <= starve + 4'd1;
      end
      write_q <= |grant;
      if (grant[SRC_MEM]) begin
        addr_q <= b1.addr;
        data_q <= b1.data;
      end else if (grant[SRC_ALU]) begin
        addr_q <= b0.addr;
        data_q <= b0.data;
      end
    end
  end

  assign bus.write   = write_q;
  assign bus.wb_addr = addr_q;
  assign bus.wb_data = data_q;

  assign bus.q_busy_1 = (bus.q_addr_1 != '0)
    && (addr_hit(b0.vld, b0.addr, bus.q_addr_1)
     || addr_hit(b1.vld, b1.addr, bus.q_addr_1)
     || addr_hit(write_q, addr_q, bus.q_addr_1));
  assign bus.q_busy_2 = (bus.q_addr_2 != '0)
    && (addr_hit(b0.vld, b0.addr, bus.q_addr_2)
     || addr_hit(b1.vld, b1.addr, bus.q_addr_2)
     || addr_hit(write_q, addr_q, bus.q_addr_2));
endmodule
